// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data access: data wins,
// but a bounded data streak lets a waiting fetch through. Optional stall counters: ARB_STALL_STATS_EN.
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic              dm_rd_wr,
    input  logic [1:0]        dm_access_size,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_wr,
    output logic [1:0]        mem_access_size,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       cnt_if_stall,
    output logic [31:0]       cnt_dm_stall
);
    localparam logic [1:0] sz_word = 2'b00;
    localparam int STREAK_W = ($clog2(MAX_D_STREAK + 1) > 3) ? $clog2(MAX_D_STREAK + 1) : 3;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t              state_q, state_d;
    logic [STREAK_W-1:0] d_streak_q, d_streak_d;
    logic                mem_en_d, mem_rd_wr_d, if_ready_d, dm_ready_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [1:0]          mem_access_size_d;
    logic [31:0]         mem_wdata_d, if_rdata_d, dm_rdata_d;
    logic                grant_d;

    // A fetch that has waited out a full data streak takes the next slot.
    assign grant_d = dm_req && !(if_req && d_streak_q == STREAK_MAX);

    always_comb begin
        state_d           = state_q;
        d_streak_d        = d_streak_q;
        mem_en_d          = mem_en;
        mem_addr_d        = mem_addr;
        mem_rd_wr_d       = mem_rd_wr;
        mem_access_size_d = mem_access_size;
        mem_wdata_d       = mem_wdata;
        if_rdata_d        = if_rdata;
        dm_rdata_d        = dm_rdata;
        if_ready_d        = 1'b0;
        dm_ready_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d           = BUSY_D;
                    mem_en_d          = 1'b1;
                    mem_addr_d        = dm_addr;
                    mem_rd_wr_d       = dm_rd_wr;
                    mem_access_size_d = dm_access_size;
                    mem_wdata_d       = dm_wdata;
                    if (!if_req)
                        d_streak_d = '0;
                    else if (d_streak_q != STREAK_MAX)
                        d_streak_d = d_streak_q + STREAK_W'(1);
                end else if (if_req) begin
                    state_d           = BUSY_I;
                    mem_en_d          = 1'b1;
                    mem_addr_d        = if_addr;
                    mem_rd_wr_d       = 1'b1;
                    mem_access_size_d = sz_word;
                    d_streak_d        = '0;
                end
            end
            BUSY_I: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_en_d   = 1'b0;
                    if_rdata_d = mem_rdata;
                    if_ready_d = 1'b1;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_en_d   = 1'b0;
                    dm_rdata_d = mem_rdata;
                    dm_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            d_streak_q      <= '0;
            mem_en          <= 1'b0;
            mem_addr        <= '0;
            mem_rd_wr       <= 1'b1;
            mem_access_size <= sz_word;
            mem_wdata       <= '0;
            if_rdata        <= '0;
            dm_rdata        <= '0;
            if_ready        <= 1'b0;
            dm_ready        <= 1'b0;
        end else begin
            state_q         <= state_d;
            d_streak_q      <= d_streak_d;
            mem_en          <= mem_en_d;
            mem_addr        <= mem_addr_d;
            mem_rd_wr       <= mem_rd_wr_d;
            mem_access_size <= mem_access_size_d;
            mem_wdata       <= mem_wdata_d;
            if_rdata        <= if_rdata_d;
            dm_rdata        <= dm_rdata_d;
            if_ready        <= if_ready_d;
            dm_ready        <= dm_ready_d;
        end
    end

`ifdef ARB_STALL_STATS_EN
    logic [31:0] cnt_if_q, cnt_dm_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_if_q <= '0;
            cnt_dm_q <= '0;
        end else begin
            if (if_req && !if_ready && cnt_if_q != '1) cnt_if_q <= cnt_if_q + 32'd1;
            if (dm_req && !dm_ready && cnt_dm_q != '1) cnt_dm_q <= cnt_dm_q + 32'd1;
        end
    end

    assign cnt_if_stall = cnt_if_q;
    assign cnt_dm_stall = cnt_dm_q;
`else
    assign cnt_if_stall = 32'd0;
    assign cnt_dm_stall = 32'd0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter; the random phase is predicted by
// a transaction-level schedule (grant time, 2+W latency, streak rule) computed up front.
module tb_mem_port_arbiter;
    localparam int MAXS = 4;
    localparam int NT   = 40;
    localparam logic [1:0] SZW = 2'b00;
`ifdef ARB_STALL_STATS_EN
    localparam logic [31:0] EXP_STALL = 32'd5;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_ready, dm_req, dm_rd_wr, dm_ready;
    logic        mem_en, mem_rd_wr, mem_ack;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, cnt_if_stall, cnt_dm_stall;
    logic [1:0]  dm_access_size, mem_access_size;

    mem_port_arbiter #(.MAX_D_STREAK(MAXS), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_rd_wr(dm_rd_wr), .dm_access_size(dm_access_size),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rd_wr(mem_rd_wr),
        .mem_access_size(mem_access_size), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .cnt_if_stall(cnt_if_stall), .cnt_dm_stall(cnt_dm_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        rd_wr;
        logic [1:0]  size;
        logic [31:0] wdata;
        int          gap;
    } txn_t;

    typedef struct {
        bit          is_d;
        int          rdy;
        logic [31:0] addr;
        logic        rd_wr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    txn_t ft[NT];
    txn_t dt[NT];
    int   wl[2*NT];
    exp_t eq[$];
    exp_t gq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_addr = '0; dm_rd_wr = 1'b1; dm_access_size = SZW; dm_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "/mem_en"}, mem_en, 1'b0);
        chk({p, "/mem_addr"}, mem_addr, 32'h0);
        chk({p, "/mem_rd_wr"}, mem_rd_wr, 1'b1);
        chk({p, "/mem_size"}, mem_access_size, SZW);
        chk({p, "/mem_wdata"}, mem_wdata, 32'h0);
        chk({p, "/if_rdata"}, if_rdata, 32'h0);
        chk({p, "/dm_rdata"}, dm_rdata, 32'h0);
        chk({p, "/readies"}, {if_ready, dm_ready}, 2'b00);
        chk({p, "/cnt_if"}, cnt_if_stall, 32'h0);
        chk({p, "/cnt_dm"}, cnt_dm_stall, 32'h0);
    endtask

    // Schedule every access from the arbitration rules: grant at max(free, arrival),
    // ready at grant+2+W, requester's next arrival = its ready cycle + gap.
    task automatic build_model();
        int tfree, fi, di, fa, da, st, n, fp, dp, g, r;
        bit f_ok, d_ok;
        exp_t e;
        tfree = 0; fi = 0; di = 0; st = 0; n = 0;
        fa = ft[0].gap; da = dt[0].gap;
        while (fi < NT || di < NT) begin
            fp = (fi < NT) ? fa : 32'h3FFF_FFFF;
            dp = (di < NT) ? da : 32'h3FFF_FFFF;
            g = (fp < dp) ? fp : dp;
            if (g < tfree) g = tfree;
            f_ok = (fp <= g);
            d_ok = (dp <= g);
            r = g + 2 + wl[n];
            n++;
            if (d_ok && !(f_ok && st == MAXS)) begin
                e = '{1'b1, r, dt[di].addr, dt[di].rd_wr, dt[di].size, dt[di].wdata};
                st = f_ok ? ((st < MAXS) ? st + 1 : st) : 0;
                di++;
                if (di < NT) da = r + dt[di].gap;
            end else begin
                e = '{1'b0, r, ft[fi].addr, 1'b1, SZW, 32'h0};
                st = 0;
                fi++;
                if (fi < NT) fa = r + ft[fi].gap;
            end
            eq.push_back(e);
            gq.push_back(e);
            tfree = r;
        end
    endtask

    initial begin
        int   nev, c, wn, wcnt, f_idx, d_idx, f_nxt, d_nxt;
        bit   f_act, d_act, prev_en;
        exp_t e;

        // Reset values
        idle_inputs();
        reset = 1'b0;
        tick(); tick();
        chk_reset_vals("por");
        reset = 1'b1;
        tick();

        // Single fetch, W = 0
        if_req = 1'b1; if_addr = 32'h8002_0000;
        tick();
        chk("f1/mem_en", mem_en, 1'b1);
        chk("f1/mem_addr", mem_addr, 32'h8002_0000);
        chk("f1/mem_rd_wr", mem_rd_wr, 1'b1);
        chk("f1/mem_size", mem_access_size, SZW);
        chk("f1/early_ready", if_ready, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'h8FBF_0004;
        tick();
        chk("f1/if_ready", if_ready, 1'b1);
        chk("f1/if_rdata", if_rdata, 32'h8FBF_0004);
        chk("f1/mem_en_off", mem_en, 1'b0);
        chk("f1/dm_ready", dm_ready, 1'b0);
        if_req = 1'b0; mem_ack = 1'b0;
        tick();
        chk("f1/pulse_width", if_ready, 1'b0);

        // Simultaneous requests, W = 1: data first, then fetch
        dm_req = 1'b1; dm_addr = 32'h8002_0100; dm_rd_wr = 1'b0; dm_access_size = SZW;
        dm_wdata = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 32'h8002_0004;
        tick();
        chk("sim/mem_en_d", mem_en, 1'b1);
        chk("sim/mem_addr_d", mem_addr, 32'h8002_0100);
        chk("sim/mem_rd_wr_d", mem_rd_wr, 1'b0);
        chk("sim/mem_wdata_d", mem_wdata, 32'hDEAD_BEEF);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        chk("sim/dm_ready_c3", dm_ready, 1'b1);
        chk("sim/if_ready_c3", if_ready, 1'b0);
        dm_req = 1'b0; mem_ack = 1'b0;
        tick();
        chk("sim/mem_en_i", mem_en, 1'b1);
        chk("sim/mem_addr_i", mem_addr, 32'h8002_0004);
        chk("sim/mem_rd_wr_i", mem_rd_wr, 1'b1);
        chk("sim/dm_ready_c4", dm_ready, 1'b0);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h3C1D_8002;
        tick();
        chk("sim/if_ready_c6", if_ready, 1'b1);
        chk("sim/if_rdata", if_rdata, 32'h3C1D_8002);
        if_req = 1'b0; mem_ack = 1'b0;
        tick();

        // Starvation guard: 4 data, 1 fetch, repeating
        do_reset();
        if_req = 1'b1; if_addr = 32'h8003_0000;
        dm_req = 1'b1; dm_addr = 32'h8004_0000; dm_rd_wr = 1'b1;
        nev = 0;
        for (int k = 0; k < 80 && nev < 10; k++) begin
            tick();
            chk("starve/exclusive", {if_ready, dm_ready} != 2'b11, 1'b1);
            if (if_ready || dm_ready) begin
                chk($sformatf("starve/ev%0d_is_fetch", nev), if_ready, (nev % 5) == 4);
                nev++;
            end
            mem_ack = mem_en;
        end
        chk("starve/count", nev, 10);
        idle_inputs();
        tick();

        // Reset in the middle of a data access, then a late ack
        do_reset();
        dm_req = 1'b1; dm_rd_wr = 1'b1; dm_addr = 32'h8005_0000;
        tick();
        chk("rmid/busy", mem_en, 1'b1);
        tick();
        reset = 1'b0; dm_req = 1'b0;
        #1;
        chk_reset_vals("rmid");
        tick();
        reset = 1'b1;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rmid/no_ready", {if_ready, dm_ready, mem_en}, 3'b000);
            tick();
        end
        chk("rmid/dm_rdata", dm_rdata, 32'h0);

        // Stray ack in IDLE, then prove the arbiter still grants immediately
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        chk("stray/no_ready", {if_ready, dm_ready, mem_en}, 3'b000);
        chk("stray/if_rdata", if_rdata, 32'h0);
        if_req = 1'b1; if_addr = 32'h8006_0000;
        tick();
        chk("stray/grant", mem_en, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        chk("stray/if_ready", if_ready, 1'b1);
        chk("stray/if_rdata2", if_rdata, 32'h1234_5678);
        if_req = 1'b0; mem_ack = 1'b0;
        tick();

        // Stall counter: fetch with W = 3
        do_reset();
        if_req = 1'b1; if_addr = 32'h8007_0000;
        tick(); tick(); tick(); tick();
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        chk("stall/if_ready", if_ready, 1'b1);
        chk("stall/cnt_if", cnt_if_stall, EXP_STALL);
        if_req = 1'b0; mem_ack = 1'b0;
        tick();
        chk("stall/cnt_if_hold", cnt_if_stall, EXP_STALL);
        chk("stall/cnt_dm", cnt_dm_stall, 32'h0);

        // Randomized traffic against the schedule model
        for (int i = 0; i < NT; i++) begin
            ft[i].addr  = $urandom();
            ft[i].rd_wr = 1'b1;
            ft[i].size  = SZW;
            ft[i].wdata = 32'h0;
            ft[i].gap   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            dt[i].addr  = $urandom();
            dt[i].rd_wr = 1'($urandom_range(0, 1));
            dt[i].size  = 2'($urandom_range(0, 2));
            dt[i].wdata = $urandom();
            dt[i].gap   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
        end
        for (int i = 0; i < 2 * NT; i++) wl[i] = int'($urandom_range(0, 3));
        build_model();
        do_reset();
        wn = 0; wcnt = 0; prev_en = 1'b0;
        f_idx = 0; d_idx = 0; f_act = 1'b0; d_act = 1'b0;
        f_nxt = ft[0].gap; d_nxt = dt[0].gap;
        for (c = 0; c < 5000 && eq.size() > 0; c++) begin
            if (c > 0) tick();
            while (eq.size() > 0 && eq[0].rdy < c) begin
                chk("rnd/missed_ready_cycle", c, eq[0].rdy);
                void'(eq.pop_front());
            end
            if (if_ready || dm_ready || (eq.size() > 0 && eq[0].rdy == c)) begin
                e = (eq.size() > 0) ? eq[0] : '{1'b0, -1, 32'h0, 1'b0, 2'b00, 32'h0};
                chk($sformatf("rnd/if_ready@%0d", c), if_ready, e.rdy == c && !e.is_d);
                chk($sformatf("rnd/dm_ready@%0d", c), dm_ready, e.rdy == c && e.is_d);
                if (e.rdy == c) begin
                    if (!e.is_d)
                        chk("rnd/if_rdata", if_rdata, mem_fn(e.addr));
                    else if (e.rd_wr)
                        chk("rnd/dm_rdata", dm_rdata, mem_fn(e.addr));
                    void'(eq.pop_front());
                end
            end
            // Memory side: check each new command, ack after its W wait cycles
            if (mem_en && !prev_en) begin
                if (gq.size() > 0) begin
                    e = gq.pop_front();
                    chk("rnd/mem_addr", mem_addr, e.addr);
                    chk("rnd/mem_rd_wr", mem_rd_wr, e.rd_wr);
                    chk("rnd/mem_size", mem_access_size, e.size);
                    if (!e.rd_wr) chk("rnd/mem_wdata", mem_wdata, e.wdata);
                end else begin
                    chk("rnd/extra_command", mem_en, 1'b0);
                end
                wcnt = (wn < 2 * NT) ? wl[wn] : 0;
                wn++;
            end
            prev_en = mem_en;
            if (mem_en && wcnt == 0) begin
                mem_ack = 1'b1; mem_rdata = mem_fn(mem_addr);
            end else begin
                mem_ack = 1'b0; mem_rdata = $urandom();
                if (mem_en) wcnt--;
            end
            // Requesters
            if (f_act && if_ready) begin
                f_act = 1'b0; f_idx++;
                if (f_idx < NT) f_nxt = c + ft[f_idx].gap;
            end
            if (!f_act && f_idx < NT && c >= f_nxt) begin
                f_act = 1'b1; if_addr = ft[f_idx].addr;
            end
            if_req = f_act;
            if (d_act && dm_ready) begin
                d_act = 1'b0; d_idx++;
                if (d_idx < NT) d_nxt = c + dt[d_idx].gap;
            end
            if (!d_act && d_idx < NT && c >= d_nxt) begin
                d_act = 1'b1;
                dm_addr = dt[d_idx].addr; dm_rd_wr = dt[d_idx].rd_wr;
                dm_access_size = dt[d_idx].size; dm_wdata = dt[d_idx].wdata;
            end
            dm_req = d_act;
        end
        chk("rnd/drained", eq.size(), 0);
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
